tpu_apb_cfg_slave: RTL and testbench
====================================

Name: tpu_apb_cfg_slave

Overview:
APB3 responder holding the TPU configuration/status registers: block enables, normalization mean and inverse variance, and start/done. It sits between the host APB bus (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/PREADY) and the TPU datapath control. It drives a level start to the core and latches the core's done pulse into a sticky status bit that the host polls.

Parameters:
REG_ADDRWIDTH, 8, APB address width (byte address)
REG_DATAWIDTH, 32, APB data width
WAIT_STATES, 0, extra ACCESS cycles with PREADY=0 before completion (0..15)
ADDR_ENABLES, 8'h00, enables register offset
ADDR_STDN, 8'h04, start/done register offset
ADDR_MEAN, 8'h08, mean register offset
ADDR_INV_VAR, 8'h0C, inverse-variance register offset

Ports:
clk  in  1  single clock; all logic on posedge
resetn  in  1  synchronous active-low reset
PADDR  in  REG_ADDRWIDTH  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB enable (access phase)
PWRITE  in  1  1=write, 0=read
PWDATA  in  REG_DATAWIDTH  write data
PRDATA  out  REG_DATAWIDTH  read data, valid when PREADY=1 on a read
PREADY  out  1  transfer completes this cycle
enable_matmul  out  1  ENABLES[0]
enable_norm  out  1  ENABLES[1]
enable_pool  out  1  ENABLES[2]
enable_activation  out  1  ENABLES[3]
mean  out  8  MEAN[7:0]
inv_var  out  8  INV_VAR[7:0]
start_tpu  out  1  STDN[0], level
done_tpu  in  1  one-cycle (or level) completion from core

Behaviour:
- Reset (resetn=0 at posedge): all registers 0, FSM=IDLE, PREADY=0, PRDATA=0, all outputs 0, wait counter 0, done sticky 0.
- FSM IDLE->SETUP when PSEL=1 & PENABLE=0. SETUP->ACCESS when PSEL=1 & PENABLE=1. ACCESS->IDLE after completion. PENABLE=1 seen in IDLE (no setup) is ignored. PSEL=0 in SETUP/ACCESS aborts to IDLE: no write, PREADY stays 0.
- PADDR/PWRITE/PWDATA captured at the SETUP edge; changes during ACCESS are ignored.
- ACCESS: wait counter counts 0..WAIT_STATES; PREADY registered, =1 for exactly one cycle when counter==WAIT_STATES (WAIT_STATES=0 -> PREADY=1 in first ACCESS cycle). Write commits on the posedge ending the PREADY=1 cycle.
- PRDATA registered, loaded on the SETUP->ACCESS edge for reads, holds until the next read; writes do not change PRDATA.
- Read map: ENABLES={28'b0,en[3:0]}; STDN={done_sticky,busy,29'b0,start}; MEAN={24'b0,mean}; INV_VAR={24'b0,inv_var}. Unmapped offsets read 0. Unused write bits ignored.
- busy = start_tpu & ~done_sticky.
- STDN write: bit0 -> start_tpu. 0->1 transition clears done_sticky in the same edge. Bits[31:1] read-only.
- done_sticky sets on any posedge with done_tpu=1 & start_tpu=1; done_tpu with start_tpu=0 is ignored. Simultaneous done_tpu=1 and start 0->1 write: clear wins (new run).
- While busy=1, writes to ENABLES/MEAN/INV_VAR are dropped (transfer still completes, PREADY=1). Writing STDN bit0=0 while busy aborts: start_tpu=0, done_sticky unchanged.
- Back-to-back transfers: SETUP may follow ACCESS directly (ACCESS->SETUP when PSEL stays 1 and PENABLE drops).

Optional Feature:
TPU_APB_PSLVERR_EN: adds output PSLVERR (1 bit, reset 0), asserted with PREADY for unmapped offsets, misaligned PADDR[1:0]!=0, and config writes dropped while busy; 0 otherwise. Without the macro, no port exists and such transfers complete silently (reads return 0, writes ignored).

Test Plan:
- Write 0xF to 0x00, read 0x00 -> PRDATA=0x0000000F, all four enables=1; write 0xD -> enable_norm=0.
- Write 0x01 to 0x08 and 0x0C -> mean=8'h01, inv_var=8'h01; read back 0x00000001 each.
- Write 1 to 0x04, read -> 0x40000001 (busy); pulse done_tpu one cycle, read -> 0x80000001, start_tpu stays 1; write 0 then 1 -> done clears, reads 0x40000001.
- While busy, write 0x0 to 0x00 -> read still 0x0000000F; (PSLVERR_EN) PSLVERR=1 on that write.
- WAIT_STATES=3: PREADY rises exactly 4 cycles after PENABLE asserted; drop PSEL after 2 ACCESS cycles -> no write, FSM IDLE.
- Assert resetn=0 mid-ACCESS with busy=1 -> next cycle all outputs 0, PREADY=0; read 0x10 -> 0x00000000.

Source files
------------

// File: rtl/tpu_apb_cfg_slave.sv
// ============================================================================
// tpu_apb_cfg_slave
// ----------------------------------------------------------------------------
// APB3 responder for the TPU configuration and status registers. It holds the
// block enables, the normalization mean and inverse variance, and the
// start/done control. It drives a level start_tpu to the core. It latches the
// core's done_tpu into a sticky status bit that the host polls.
//
// Register map (byte offsets, 32-bit words):
//   ADDR_ENABLES : {28'b0, activation, pool, norm, matmul}
//   ADDR_STDN    : {done_sticky, busy, 29'b0, start}  (only bit0 is writable)
//   ADDR_MEAN    : {24'b0, mean}
//   ADDR_INV_VAR : {24'b0, inv_var}
//   Unmapped or misaligned offsets read 0 and ignore writes.
//
// Handshake: a transfer is one setup cycle (PSEL=1, PENABLE=0) followed by an
// access phase (PSEL=1, PENABLE=1). The access phase lasts until PREADY=1.
// PADDR/PWRITE/PWDATA are captured at the end of the setup cycle and are not
// looked at again. PREADY is registered and is high for exactly one cycle;
// the transfer completes at the rising edge that ends that cycle, and a write
// takes effect at that edge. Dropping PSEL before completion abandons the
// transfer with no side effects.
//
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   PADDR .. PWDATA    APB request from the host
//   PRDATA, PREADY     APB response (PRDATA holds the most recent read)
//   PSLVERR            error response (present only with TPU_APB_PSLVERR_EN)
//   enable_*           block enables, ENABLES[3:0]
//   mean, inv_var      normalization parameters
//   start_tpu          level start, STDN[0]
//   done_tpu           completion from the core (pulse or level)
//   state_dbg          current FSM state (0=IDLE, 1=SETUP, 2=ACCESS)
//
// Build option:
//   TPU_APB_PSLVERR_EN  adds PSLVERR. The response is an error for unmapped or
//                       misaligned offsets and for config writes dropped while
//                       the core is busy.
// ============================================================================
`default_nettype none

module tpu_apb_cfg_slave #(
    parameter int REG_ADDRWIDTH = 8,
    parameter int REG_DATAWIDTH = 32,
    parameter int WAIT_STATES   = 0,
    parameter logic [REG_ADDRWIDTH-1:0] ADDR_ENABLES = REG_ADDRWIDTH'('h00),
    parameter logic [REG_ADDRWIDTH-1:0] ADDR_STDN    = REG_ADDRWIDTH'('h04),
    parameter logic [REG_ADDRWIDTH-1:0] ADDR_MEAN    = REG_ADDRWIDTH'('h08),
    parameter logic [REG_ADDRWIDTH-1:0] ADDR_INV_VAR = REG_ADDRWIDTH'('h0C)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [REG_ADDRWIDTH-1:0] PADDR,
    input  logic                     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [REG_DATAWIDTH-1:0] PWDATA,
    output logic [REG_DATAWIDTH-1:0] PRDATA,
    output logic                     PREADY,
`ifdef TPU_APB_PSLVERR_EN
    output logic                     PSLVERR,
`endif
    output logic                     enable_matmul,
    output logic                     enable_norm,
    output logic                     enable_pool,
    output logic                     enable_activation,
    output logic [7:0]               mean,
    output logic [7:0]               inv_var,
    output logic                     start_tpu,
    input  logic                     done_tpu,
    output logic [1:0]               state_dbg
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Request captured at the end of the setup cycle
    logic [REG_ADDRWIDTH-1:0] addr_q;
    logic                     write_q;
    logic [REG_DATAWIDTH-1:0] wdata_q;

    logic [3:0]               wait_cnt_q;
    logic [3:0]               cnt_inc;
    logic                     pready_q;
    logic [REG_DATAWIDTH-1:0] prdata_q;

    // Architectural registers
    logic [3:0] en_q;
    logic [7:0] mean_q;
    logic [7:0] inv_var_q;
    logic       start_q;
    logic       done_q;
    logic       busy;

    // FSM strobes
    logic capture;
    logic enter_access;
    logic complete;

    // Decode of the captured address
    logic aligned;
    logic hit_en, hit_stdn, hit_mean, hit_iv, hit_cfg;
    logic wr_commit;
    logic start_rise;
    logic [REG_DATAWIDTH-1:0] rd_word;

    // Only the low byte of write data is ever stored
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^wdata_q[REG_DATAWIDTH-1:8];

    assign busy = start_q & ~done_q;

    // ------------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        enter_access = 1'b0;
        complete     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // PENABLE without a preceding setup cycle is ignored
                if (PSEL && !PENABLE) begin
                    state_d = ST_SETUP;
                    capture = 1'b1;
                end
            end
            ST_SETUP: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (PENABLE) begin
                    state_d      = ST_ACCESS;
                    enter_access = 1'b1;
                end else begin
                    // Setup held for another cycle: follow the newest request
                    capture = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (!PENABLE) begin
                    // Host started a new setup directly; treat it as one
                    state_d = ST_SETUP;
                    capture = 1'b1;
                end else if (pready_q) begin
                    state_d  = ST_IDLE;
                    complete = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Address decode and read mux (always from the captured address)
    // ------------------------------------------------------------------------
    assign aligned  = (addr_q[1:0] == 2'b00);
    assign hit_en   = aligned && (addr_q == ADDR_ENABLES);
    assign hit_stdn = aligned && (addr_q == ADDR_STDN);
    assign hit_mean = aligned && (addr_q == ADDR_MEAN);
    assign hit_iv   = aligned && (addr_q == ADDR_INV_VAR);
    assign hit_cfg  = hit_en | hit_mean | hit_iv;

    always_comb begin
        rd_word = '0;
        if (hit_en) begin
            rd_word[3:0] = en_q;
        end
        if (hit_stdn) begin
            rd_word[REG_DATAWIDTH-1] = done_q;
            rd_word[REG_DATAWIDTH-2] = busy;
            rd_word[0]               = start_q;
        end
        if (hit_mean) begin
            rd_word[7:0] = mean_q;
        end
        if (hit_iv) begin
            rd_word[7:0] = inv_var_q;
        end
    end

    // ------------------------------------------------------------------------
    // Wait-state counter, PREADY and PRDATA
    // ------------------------------------------------------------------------
    assign cnt_inc = wait_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
            prdata_q   <= '0;
        end else begin
            wait_cnt_q <= '0;
            pready_q   <= 1'b0;
            if (enter_access) begin
                // Counter value 0 belongs to the first access cycle
                pready_q <= (WAIT_LAST == 4'd0);
                if (!write_q) begin
                    prdata_q <= rd_word;
                end
            end else if (state_q == ST_ACCESS && state_d == ST_ACCESS) begin
                wait_cnt_q <= cnt_inc;
                pready_q   <= (cnt_inc == WAIT_LAST);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register writes and done tracking
    // ------------------------------------------------------------------------
    assign wr_commit  = complete & write_q;
    assign start_rise = wr_commit & hit_stdn & wdata_q[0] & ~start_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            en_q      <= '0;
            mean_q    <= '0;
            inv_var_q <= '0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Configuration is frozen while the core is running
            if (wr_commit && !busy) begin
                if (hit_en) begin
                    en_q <= wdata_q[3:0];
                end
                if (hit_mean) begin
                    mean_q <= wdata_q[7:0];
                end
                if (hit_iv) begin
                    inv_var_q <= wdata_q[7:0];
                end
            end
            if (wr_commit && hit_stdn) begin
                start_q <= wdata_q[0];
            end
            // A new run clears the sticky done, even against a same-edge done
            if (start_rise) begin
                done_q <= 1'b0;
            end else if (done_tpu && start_q) begin
                done_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign PRDATA            = prdata_q;
    assign PREADY            = pready_q;
    assign enable_matmul     = en_q[0];
    assign enable_norm       = en_q[1];
    assign enable_pool       = en_q[2];
    assign enable_activation = en_q[3];
    assign mean              = mean_q;
    assign inv_var           = inv_var_q;
    assign start_tpu         = start_q;
    assign state_dbg         = state_q;

`ifdef TPU_APB_PSLVERR_EN
    // The decode is stable for the whole access phase, so the error is
    // qualified by the registered PREADY and lines up with the completion
    logic xfer_err;
    assign xfer_err = ~(hit_cfg | hit_stdn) | (write_q & hit_cfg & busy);
    assign PSLVERR  = pready_q & xfer_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tpu_apb_cfg_slave.sv
`timescale 1ns/1ps

module tb_tpu_apb_cfg_slave;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [7:0]  paddr;
    logic        psel_a, psel_b, penable, pwrite;
    logic [31:0] pwdata;
    logic        done_tpu;

    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b;
    logic        en_mm_a, en_norm_a, en_pool_a, en_act_a;
    logic        en_mm_b, en_norm_b, en_pool_b, en_act_b;
    logic [7:0]  mean_a, inv_var_a, mean_b, inv_var_b;
    logic        start_a, start_b;
    logic [1:0]  state_a, state_b;
`ifdef TPU_APB_PSLVERR_EN
    logic        pslverr_a, pslverr_b;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Instance A: no wait states
    tpu_apb_cfg_slave #(.WAIT_STATES(0)) u_dut (
        .clk(clk), .resetn(resetn), .PADDR(paddr), .PSEL(psel_a),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(prdata_a), .PREADY(pready_a),
`ifdef TPU_APB_PSLVERR_EN
        .PSLVERR(pslverr_a),
`endif
        .enable_matmul(en_mm_a), .enable_norm(en_norm_a),
        .enable_pool(en_pool_a), .enable_activation(en_act_a),
        .mean(mean_a), .inv_var(inv_var_a), .start_tpu(start_a),
        .done_tpu(done_tpu), .state_dbg(state_a)
    );

    // Instance B: three wait states
    tpu_apb_cfg_slave #(.WAIT_STATES(3)) u_dut_ws (
        .clk(clk), .resetn(resetn), .PADDR(paddr), .PSEL(psel_b),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(prdata_b), .PREADY(pready_b),
`ifdef TPU_APB_PSLVERR_EN
        .PSLVERR(pslverr_b),
`endif
        .enable_matmul(en_mm_b), .enable_norm(en_norm_b),
        .enable_pool(en_pool_b), .enable_activation(en_act_b),
        .mean(mean_b), .inv_var(inv_var_b), .start_tpu(start_b),
        .done_tpu(done_tpu), .state_dbg(state_b)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pins_a();
        return {28'b0, en_act_a, en_pool_a, en_norm_a, en_mm_a};
    endfunction

    function automatic logic [31:0] pins_b();
        return {28'b0, en_act_b, en_pool_b, en_norm_b, en_mm_b};
    endfunction

    // ---------------- driver ----------------
    // Entered and left at 1ns after a rising edge. Returns the number of
    // edges from PENABLE assertion until PREADY is seen. done_at_end raises
    // done_tpu for the completing edge only.
    task automatic apb_xfer(input bit inst_b, input logic [7:0] addr, input bit wr,
                            input logic [31:0] wdata, input bit done_at_end,
                            output logic [31:0] rdata, output int lat, output logic err);
        bit seen;
        seen  = 1'b0;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        psel_a  = !inst_b;
        psel_b  = inst_b;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (inst_b ? pready_b : pready_a) begin
                seen  = 1'b1;
                rdata = inst_b ? prdata_b : prdata_a;
`ifdef TPU_APB_PSLVERR_EN
                err   = inst_b ? pslverr_b : pslverr_a;
`endif
                done_tpu = done_at_end;
            end
        end
        @(posedge clk); #1;
        done_tpu = 1'b0;
        psel_a   = 1'b0;
        psel_b   = 1'b0;
        penable  = 1'b0;
    endtask

    task automatic wr_reg(input bit b, input logic [7:0] a, input logic [31:0] d,
                          input int exp_lat, input logic exp_err, input string tag);
        logic [31:0] rd;
        int          lat;
        logic        err;
        apb_xfer(b, a, 1'b1, d, 1'b0, rd, lat, err);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
`ifdef TPU_APB_PSLVERR_EN
        chk({tag, "_slverr"}, {31'b0, err}, {31'b0, exp_err});
`endif
    endtask

    task automatic rd_reg(input bit b, input logic [7:0] a, input logic [31:0] exp,
                          input int exp_lat, input logic exp_err, input string tag);
        logic [31:0] rd;
        int          lat;
        logic        err;
        apb_xfer(b, a, 1'b0, 32'h0, 1'b0, rd, lat, err);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk(tag, rd, exp);
`ifdef TPU_APB_PSLVERR_EN
        chk({tag, "_slverr"}, {31'b0, err}, {31'b0, exp_err});
`endif
    endtask

    task automatic pulse_done();
        done_tpu = 1'b1;
        @(posedge clk); #1;
        done_tpu = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int          lat;
        logic        err;

        resetn   = 1'b0;
        psel_a   = 1'b0;
        psel_b   = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = 8'h00;
        pwdata   = 32'h0;
        done_tpu = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_pready_a", {31'b0, pready_a}, 32'h0);
        chk("rst_prdata_a", prdata_a, 32'h0);
        chk("rst_en_a", pins_a(), 32'h0);
        chk("rst_mean_inv_a", {16'b0, mean_a, inv_var_a}, 32'h0);
        chk("rst_start_a", {31'b0, start_a}, 32'h0);
        chk("rst_state_a", {30'b0, state_a}, 32'h0);
        chk("rst_pready_b", {31'b0, pready_b}, 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Enables
        wr_reg(0, 8'h00, 32'h0000_000F, 1, 1'b0, "wr_en_f");
        chk("en_pins_f", pins_a(), 32'h0000_000F);
        rd_reg(0, 8'h00, 32'h0000_000F, 1, 1'b0, "rd_en_f");
        wr_reg(0, 8'h00, 32'h0000_000D, 1, 1'b0, "wr_en_d");
        chk("en_norm_off", {31'b0, en_norm_a}, 32'h0);
        chk("en_pins_d", pins_a(), 32'h0000_000D);
        wr_reg(0, 8'h00, 32'hFFFF_FFFF, 1, 1'b0, "wr_en_all");
        rd_reg(0, 8'h00, 32'h0000_000F, 1, 1'b0, "rd_en_masked");

        // Mean / inverse variance
        wr_reg(0, 8'h08, 32'h0000_0001, 1, 1'b0, "wr_mean_1");
        wr_reg(0, 8'h0C, 32'h0000_0001, 1, 1'b0, "wr_iv_1");
        chk("mean_pin_1", {24'b0, mean_a}, 32'h1);
        chk("iv_pin_1", {24'b0, inv_var_a}, 32'h1);
        rd_reg(0, 8'h08, 32'h0000_0001, 1, 1'b0, "rd_mean_1");
        rd_reg(0, 8'h0C, 32'h0000_0001, 1, 1'b0, "rd_iv_1");
        wr_reg(0, 8'h08, 32'h0000_01A5, 1, 1'b0, "wr_mean_a5");
        rd_reg(0, 8'h08, 32'h0000_00A5, 1, 1'b0, "rd_mean_a5");

        // Unmapped and misaligned offsets
        rd_reg(0, 8'h10, 32'h0, 1, 1'b1, "rd_unmapped");
        rd_reg(0, 8'h01, 32'h0, 1, 1'b1, "rd_misaligned");
        wr_reg(0, 8'h10, 32'hFFFF_FFFF, 1, 1'b1, "wr_unmapped");
        rd_reg(0, 8'h00, 32'h0000_000F, 1, 1'b0, "rd_en_after_unmapped");

        // Start / done
        wr_reg(0, 8'h04, 32'h0000_0001, 1, 1'b0, "wr_start");
        chk("start_pin_1", {31'b0, start_a}, 32'h1);
        rd_reg(0, 8'h04, 32'h4000_0001, 1, 1'b0, "rd_stdn_busy");
        pulse_done();
        rd_reg(0, 8'h04, 32'h8000_0001, 1, 1'b0, "rd_stdn_done");
        chk("start_pin_hold", {31'b0, start_a}, 32'h1);
        wr_reg(0, 8'h04, 32'h0000_0000, 1, 1'b0, "wr_start_0");
        rd_reg(0, 8'h04, 32'h8000_0000, 1, 1'b0, "rd_stdn_done_kept");
        wr_reg(0, 8'h04, 32'h0000_0001, 1, 1'b0, "wr_restart");
        rd_reg(0, 8'h04, 32'h4000_0001, 1, 1'b0, "rd_stdn_restart");

        // Config writes dropped while busy
        wr_reg(0, 8'h00, 32'h0000_0000, 1, 1'b1, "wr_en_busy");
        rd_reg(0, 8'h00, 32'h0000_000F, 1, 1'b0, "rd_en_busy");
        chk("en_pins_busy", pins_a(), 32'h0000_000F);
        wr_reg(0, 8'h08, 32'h0000_0055, 1, 1'b1, "wr_mean_busy");
        chk("mean_pin_busy", {24'b0, mean_a}, 32'h0000_00A5);

        // Abort, done ignored while idle, same-edge done vs restart
        wr_reg(0, 8'h04, 32'h0000_0000, 1, 1'b0, "wr_abort");
        chk("start_pin_abort", {31'b0, start_a}, 32'h0);
        rd_reg(0, 8'h04, 32'h0000_0000, 1, 1'b0, "rd_stdn_abort");
        pulse_done();
        rd_reg(0, 8'h04, 32'h0000_0000, 1, 1'b0, "rd_stdn_done_ignored");
        apb_xfer(0, 8'h04, 1'b1, 32'h0000_0001, 1'b1, rd, lat, err);
        chk("wr_start_with_done_lat", 32'(lat), 32'd1);
        rd_reg(0, 8'h04, 32'h4000_0001, 1, 1'b0, "rd_stdn_clear_wins");

        // PENABLE without setup is ignored (instance B is idle, not busy)
        psel_b  = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'h08;
        pwdata  = 32'h0000_0033;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("noset_state_b", {30'b0, state_b}, 32'h0);
        chk("noset_pready_b", {31'b0, pready_b}, 32'h0);
        psel_b  = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        chk("noset_mean_b", {24'b0, mean_b}, 32'h0);

        // Wait states on instance B: PREADY four edges after PENABLE
        wr_reg(1, 8'h00, 32'h0000_0007, 4, 1'b0, "ws_wr_en");
        chk("ws_en_pins", pins_b(), 32'h0000_0007);
        rd_reg(1, 8'h00, 32'h0000_0007, 4, 1'b0, "ws_rd_en");

        // Abort after two access cycles on instance B
        psel_b  = 1'b1;
        penable = 1'b0;
        paddr   = 8'h00;
        pwrite  = 1'b1;
        pwdata  = 32'h0000_0002;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("abort_state_access", {30'b0, state_b}, 32'h2);
        chk("abort_pready_1", {31'b0, pready_b}, 32'h0);
        @(posedge clk); #1;
        chk("abort_pready_2", {31'b0, pready_b}, 32'h0);
        psel_b  = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        chk("abort_state_idle", {30'b0, state_b}, 32'h0);
        chk("abort_pready_3", {31'b0, pready_b}, 32'h0);
        chk("abort_en_pins", pins_b(), 32'h0000_0007);
        rd_reg(1, 8'h00, 32'h0000_0007, 4, 1'b0, "abort_rd_en");

        // Reset in the middle of an access while instance A is busy
        psel_a  = 1'b1;
        penable = 1'b0;
        paddr   = 8'h08;
        pwrite  = 1'b1;
        pwdata  = 32'h0000_0077;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        chk("midrst_pready_before", {31'b0, pready_a}, 32'h1);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("midrst_pready", {31'b0, pready_a}, 32'h0);
        chk("midrst_prdata", prdata_a, 32'h0);
        chk("midrst_en", pins_a(), 32'h0);
        chk("midrst_mean_inv", {16'b0, mean_a, inv_var_a}, 32'h0);
        chk("midrst_start", {31'b0, start_a}, 32'h0);
        chk("midrst_state", {30'b0, state_a}, 32'h0);
        psel_a  = 1'b0;
        penable = 1'b0;
        resetn  = 1'b1;
        @(posedge clk); #1;
        rd_reg(0, 8'h10, 32'h0, 1, 1'b1, "postrst_rd_unmapped");
        rd_reg(0, 8'h04, 32'h0, 1, 1'b0, "postrst_rd_stdn");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
